b2_serial_adder: RTL and testbench
==================================

# b2_serial_adder

Bit-serial base-2 adder computing x + y + cin over N clock cycles, one bit per cycle, LSB first, using a single full-adder cell and a carry flip-flop. It performs the inverse arithmetic operation of the combinational base-2 half subtractor. It is the sequential building block for datapaths that trade area for latency. Operation start and completion follow the soc/eoc four-phase handshake.

## Interface
- N, 8, operand and result width in bits (N ≥ 2)
- clock  input  1  system clock; all state updates on the rising edge
- reset_  input  1  asynchronous, active-low reset
- soc  input  1  start of conversion (four-phase handshake request)
- x  input  N  first addend, sampled only at start
- y  input  N  second addend, sampled only at start
- cin  input  1  carry in, sampled only at start
- s  output  N  sum, registered
- cout  output  1  carry out of bit N-1, registered
- eoc  output  1  end of conversion; 1 = idle or result valid
- ovf  output  1  signed (two's complement) overflow; present only with B2_SERIAL_ADDER_OVF_EN

## Operation
- Reset (reset_=0, asynchronous): state=IDLE, s=0, cout=0, eoc=1, ovf=0, internal shift registers, carry FF and bit counter cleared. An operation in progress is abandoned. No result is produced.
- IDLE (eoc=1): when soc=1 at an edge:
  - load x and y into internal shift registers;
  - load cin into the carry FF;
  - clear the counter;
  - go to CALC.
- CALC (eoc=0): each edge performs one full-adder step on the LSBs of the shift registers and the carry FF:
  - sum bit shifted into the internal result register from the MSB side;
  - carry FF updated;
  - operand registers shifted right;
  - counter incremented.
- After the N-th step:
  - copy the internal result to s and the carry FF to cout;
  - go to WAIT.
- WAIT (eoc=1): s, cout and ovf are stable. Go to IDLE when soc=0 at an edge. While soc stays 1, no new operation starts.
- Full-adder step: sum = a^b^c; carry = (a&b)|(c&(a^b)).
- Width: the result is exactly N bits plus cout. Arithmetic is modulo 2^N, with carry out of bit N-1 reported in cout.
- x, y and cin changes during CALC or WAIT have no effect.
- soc changes during CALC are ignored.
- s and cout hold the previous result from completion until the next completion.

## Timing
- soc sampled 1 at edge k → eoc=0 after edge k.
- Steps occur at edges k+1 … k+N.
- s, cout and ovf update, and eoc=1, after edge k+N. eoc is low for exactly N cycles.
- Minimum handshake period: N+2 edges (start, N steps, WAIT→IDLE), plus the soc=0 turnaround.
- Reset assertion acts immediately, not at the next edge. Release requires soc=0 or a fresh soc edge sequence: if soc=1 at the first edge after release, an operation starts from IDLE.

## Configuration
- B2_SERIAL_ADDER_OVF_EN defined:
  - ovf port exists;
  - an extra FF captures the carry into bit N-1 during step N;
  - at completion, ovf = carry_into_msb ^ cout, updated together with s;
  - reset value 0.
- Not defined:
  - no ovf port and no extra FF;
  - all other behaviour identical.

## Test plan
- Reset: assert reset_=0 midway through CALC (step 4 of 8) → immediately eoc=1, s=0x00, cout=0, ovf=0; after release with soc=0, eoc stays 1 and s stays 0x00.
- N=8, x=0x5A, y=0x3C, cin=0 → eoc low exactly 8 cycles, then s=0x96, cout=0, ovf=1.
- N=8, x=0xFF, y=0x01, cin=0 → s=0x00, cout=1, ovf=0.
- N=8, x=0xFF, y=0xFF, cin=1 → s=0xFF, cout=1, ovf=0; then x=0x7F, y=0x00, cin=1 → s=0x80, cout=0, ovf=1.
- Inputs changed to x=0x00, y=0x00 during CALC of 0x12+0x34 → result s=0x46.
- Handshake: hold soc=1 for 5 cycles after eoc rises → no restart and s stable; drop soc then raise it → new operation, eoc falls one edge later.

Source files
------------

// File: rtl/b2_serial_adder.sv
// rtl/b2_serial_adder.sv - bit-serial base-2 adder (x + y + cin, LSB first, soc/eoc handshake); define B2_SERIAL_ADDER_OVF_EN to add the ovf output
module b2_serial_adder #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout,
`ifdef B2_SERIAL_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic         eoc
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  // Operand shift registers; bit 0 feeds the full-adder cell each step.
  logic [N-1:0]   xa_q;
  logic [N-1:0]   yb_q;
  // Partial result: N-1 bits suffice because the N-th sum bit goes straight to s.
  logic [N-2:0]   res_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;

  logic           start;
  logic           step;
  logic           last_step;
  logic           sum_bit;
  logic           carry_nxt;
  logic [N-1:0]   res_ext;

  assign start     = (state_q == ST_IDLE) && soc;
  assign step      = (state_q == ST_CALC);
  assign last_step = step && (cnt_q == CW'(N - 1));

  // Single full-adder cell on the operand LSBs and the carry flip-flop.
  assign sum_bit   = xa_q[0] ^ yb_q[0] ^ carry_q;
  assign carry_nxt = (xa_q[0] & yb_q[0]) | (carry_q & (xa_q[0] ^ yb_q[0]));

  // New sum bit enters from the MSB side; on the final step this is the full result.
  assign res_ext   = {sum_bit, res_q};

  // State register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start on soc in IDLE, finish after N steps, re-arm once soc drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (soc) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_step) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!soc) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: eoc is low only while a conversion is running.
  always_comb begin
    eoc = 1'b1;
    if (state_q == ST_CALC) begin
      eoc = 1'b0;
    end
  end

  // Datapath: load operands at start, then one shift/add step per cycle in CALC.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      xa_q    <= '0;
      yb_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start) begin
      xa_q    <= x;
      yb_q    <= y;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (step) begin
      xa_q    <= xa_q >> 1;
      yb_q    <= yb_q >> 1;
      res_q   <= res_ext[N-1:1];
      carry_q <= carry_nxt;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  // Result registers: updated only on the last step so they hold between completions.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      s    <= '0;
      cout <= 1'b0;
    end else if (last_step) begin
      s    <= res_ext;
      cout <= carry_nxt;
    end
  end

`ifdef B2_SERIAL_ADDER_OVF_EN
  // Signed overflow: carry into the MSB (carry_q during the last step) differs from carry out.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      ovf <= 1'b0;
    end else if (last_step) begin
      ovf <= carry_q ^ carry_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_b2_serial_adder.sv
// tb/tb_b2_serial_adder.sv - self-checking bench for b2_serial_adder against an arithmetic reference model
module tb_b2_serial_adder;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset_;
  logic         soc;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic [N-1:0] s;
  logic         cout;
  logic         eoc;
`ifdef B2_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  b2_serial_adder #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .x      (x),
    .y      (y),
    .cin    (cin),
    .s      (s),
    .cout   (cout),
`ifdef B2_SERIAL_ADDER_OVF_EN
    .ovf    (ovf),
`endif
    .eoc    (eoc)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain (N+1)-bit addition.
  function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // Reference: two's complement overflow when like-signed operands give an opposite-signed sum.
  function automatic logic ref_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] r;
    r = ref_sum(a, b, c);
    return (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
  endfunction

  // Wait for eoc to return high, counting low cycles; optionally disturb inputs meanwhile.
  // mode: 0 = leave inputs, 1 = zero them, 2 = randomize them.
  task automatic wait_done(input int mode, output int low);
    low = 0;
    while (eoc === 1'b0 && low < 4 * N) begin
      low++;
      if (mode == 1) begin
        x = '0; y = '0; cin = 1'b0;
      end else if (mode == 2) begin
        x = N'($urandom); y = N'($urandom); cin = 1'($urandom);
      end
      @(negedge clock);
    end
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    logic [N:0] r;
    r = ref_sum(a, b, c);
    check({tag, "_s"}, 32'(s), 32'(r[N-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(r[N]));
`ifdef B2_SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(a, b, c)));
`endif
  endtask

  // Full handshake: request, count eoc-low cycles, check result, optionally release soc.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input int mode, input bit release_soc);
    int low;
    @(negedge clock);
    x = a; y = b; cin = c; soc = 1'b1;
    @(negedge clock);
    wait_done(mode, low);
    check({tag, "_eoc_low"}, 32'(low), 32'(N));
    check_result(tag, a, b, c);
    if (release_soc) begin
      soc = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    logic [N-1:0] s_prev;
    int low;

    reset_ = 1'b0; soc = 1'b0; x = '0; y = '0; cin = 1'b0;
    #1;
    check("rst_eoc", 32'(eoc), 32'd1);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clock);
    reset_ = 1'b1;

    run_op("v5a3c", 8'h5A, 8'h3C, 1'b0, 0, 1'b1);
    run_op("vff01", 8'hFF, 8'h01, 1'b0, 0, 1'b1);
    run_op("vffff", 8'hFF, 8'hFF, 1'b1, 0, 1'b1);
    run_op("v7f00", 8'h7F, 8'h00, 1'b1, 0, 1'b1);
    run_op("vchg", 8'h12, 8'h34, 1'b0, 1, 1'b1);

    // Reset midway through CALC: start 0x5A+0x3C, abandon after 4 steps.
    @(negedge clock);
    x = 8'h5A; y = 8'h3C; cin = 1'b0; soc = 1'b1;
    @(negedge clock);
    repeat (4) @(negedge clock);
    check("mid_eoc_busy", 32'(eoc), 32'd0);
    reset_ = 1'b0;
    #1;
    check("mid_rst_eoc", 32'(eoc), 32'd1);
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
`ifdef B2_SERIAL_ADDER_OVF_EN
    check("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
    soc = 1'b0;
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_eoc", 32'(eoc), 32'd1);
      check("post_rst_s", 32'(s), 32'd0);
    end

    // Handshake: soc held high after completion must not restart.
    run_op("hs", 8'hA5, 8'h1B, 1'b1, 0, 1'b0);
    s_prev = s;
    repeat (5) begin
      @(negedge clock);
      check("hs_hold_eoc", 32'(eoc), 32'd1);
      check("hs_hold_s", 32'(s), 32'(s_prev));
    end
    soc = 1'b0;
    x = 8'h80; y = 8'h80; cin = 1'b0;
    @(negedge clock);
    soc = 1'b1;
    @(negedge clock);
    check("hs_restart_eoc", 32'(eoc), 32'd0);
    wait_done(0, low);
    check("hs2_eoc_low", 32'(low), 32'(N));
    check_result("hs2", 8'h80, 8'h80, 1'b0);
    soc = 1'b0;
    @(negedge clock);

    // Randomized operations, some with input disturbance during CALC.
    for (int i = 0; i < 40; i++) begin
      run_op("rnd", N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
